spi_mem_arb: RTL and testbench

SPI_MEM_ARB -- requirements
Module: spi_mem_arb

---
 rtl/spi_mem_pkg.sv | 13 +
 rtl/spi_mem_arb_if.sv | 34 +++
 rtl/spi_rr_arb.sv | 31 +++
 rtl/spi_mem_arb.sv | 116 +++++++++++
 tb/tb_spi_mem_arb.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory arbiter.
package spi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ADDR_LIMIT = 32;
    localparam int SPI_DATA_W = 8;

endpackage

// File: rtl/spi_mem_arb_if.sv
// Requester and SPI-side signal bundle; slave = arbiter, master = requesters plus SPI interface.
interface spi_mem_arb_if #(
    parameter int NUM_REQ = 2
);
    import spi_mem_pkg::*;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_wr;
    logic [SPI_DATA_W*NUM_REQ-1:0] req_addr;
    logic [SPI_DATA_W*NUM_REQ-1:0] req_din;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic                          rsp_err;
    logic [SPI_DATA_W-1:0]         rsp_dout;
    logic                          timeout;
    logic                          m_rst;
    logic                          m_wr;
    logic [SPI_DATA_W-1:0]         m_addr;
    logic [SPI_DATA_W-1:0]         m_din;
    logic [SPI_DATA_W-1:0]         m_dout;
    logic                          m_done;
    logic                          m_err;

    modport slave (
        input  req, req_wr, req_addr, req_din, m_dout, m_done, m_err,
        output gnt, rsp_valid, rsp_err, rsp_dout, timeout, m_rst, m_wr, m_addr, m_din
    );

    modport master (
        output req, req_wr, req_addr, req_din, m_dout, m_done, m_err,
        input  gnt, rsp_valid, rsp_err, rsp_dout, timeout, m_rst, m_wr, m_addr, m_din
    );

endinterface

// File: rtl/spi_rr_arb.sv
// Combinational round-robin picker: search starts one past the last winner.
module spi_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    int   cand;
    logic found;

    always_comb begin
        // NOTE: every output gets a default before the search loop, so no path leaves a latch.
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_idx) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_mem_arb.sv
// Round-robin arbiter giving NUM_REQ requesters exclusive use of one SPI memory interface.
// Define SPI_MEM_ARB_TIMEOUT_EN to add a BUSY watchdog that aborts after TIMEOUT_CYCLES.
module spi_mem_arb
    import spi_mem_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic          clk,
    input logic          rst,
    spi_mem_arb_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("spi_mem_arb: NUM_REQ or TIMEOUT_CYCLES out of range");
    end

    state_t                state, state_next;
    logic [IDX_W-1:0]      last_winner, win_idx;
    logic [NUM_REQ-1:0]    win_onehot, gnt_q, rsp_valid_q;
    logic                  m_rst_q, m_wr_q, rsp_err_q;
    logic [SPI_DATA_W-1:0] m_addr_q, m_din_q, rsp_dout_q;
    logic                  busy_exit, wdog_hit;

    spi_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_arb (
        .req      (bus.req),
        .last_idx (last_winner),
        .onehot   (win_onehot),
        .idx      (win_idx)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|bus.req) state_next = BUSY;
            BUSY:    if (bus.m_done || wdog_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy_exit = (state == BUSY) && (bus.m_done || wdog_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_dout_q  <= '0;
            m_rst_q     <= 1'b1;
            m_wr_q      <= 1'b0;
            m_addr_q    <= '0;
            m_din_q     <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (state == IDLE && |bus.req) begin
                last_winner <= win_idx;
                gnt_q       <= win_onehot;
                m_rst_q     <= 1'b0;
                m_wr_q      <= bus.req_wr[win_idx];
                m_addr_q    <= bus.req_addr[SPI_DATA_W*int'(win_idx) +: SPI_DATA_W];
                m_din_q     <= bus.req_din[SPI_DATA_W*int'(win_idx) +: SPI_DATA_W];
            end
            // m_done takes precedence over a watchdog hit on the same edge
            if (busy_exit) begin
                rsp_valid_q <= gnt_q;
                m_rst_q     <= 1'b1;
                rsp_err_q   <= bus.m_done ? bus.m_err  : 1'b1;
                rsp_dout_q  <= bus.m_done ? bus.m_dout : '0;
            end
            if (state == RESP) gnt_q <= '0;
        end
    end

`ifdef SPI_MEM_ARB_TIMEOUT_EN
    logic [15:0] wdog;
    logic        timeout_q;

    assign wdog_hit = (state == BUSY) && (wdog == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wdog_hit && !bus.m_done;
            if (state == BUSY) wdog <= wdog + 16'd1;
            else               wdog <= '0;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign wdog_hit    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_dout  = rsp_dout_q;
    assign bus.m_rst     = m_rst_q;
    assign bus.m_wr      = m_wr_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_din     = m_din_q;

endmodule

// File: tb/tb_spi_mem_arb.sv
// Directed bench for spi_mem_arb: scoreboard of expected responses plus a small SPI memory model.
module tb_spi_mem_arb;
    import spi_mem_pkg::*;

    localparam int NUM_REQ        = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int SPI_LAT        = 3;

    logic clk = 1'b0;
    logic rst;

    spi_mem_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    spi_mem_arb #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic       err;
        logic       chk_dout;
        logic [7:0] dout;
        logic       tmo;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] shadow  [ADDR_LIMIT];
    logic [7:0] spi_mem [ADDR_LIMIT];
    int         checks = 0;
    int         errors = 0;
    int         spi_cnt = 0;
    bit         spi_stall = 1'b0;
    bit         err_glitch = 1'b0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic wr, logic [7:0] addr, logic [7:0] din);
        bus.req_wr[i]         = wr;
        bus.req_addr[8*i +: 8] = addr;
        bus.req_din[8*i +: 8]  = din;
    endtask

    task automatic expect_txn(int idx, logic wr, logic [7:0] addr, logic [7:0] din, logic tmo);
        exp_t e;
        e.idx      = idx;
        e.tmo      = tmo;
        e.err      = tmo || (addr >= 8'(ADDR_LIMIT));
        e.chk_dout = tmo || (!wr && !e.err);
        e.dout     = (!tmo && e.chk_dout) ? shadow[addr[4:0]] : 8'h00;
        if (!tmo && wr && addr < 8'(ADDR_LIMIT)) shadow[addr[4:0]] = din;
        sb.push_back(e);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_gnt"},       32'(bus.gnt), 0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err), 0);
        check({tag, "_rsp_dout"},  32'(bus.rsp_dout), 0);
        check({tag, "_timeout"},   32'(bus.timeout), 0);
        check({tag, "_m_rst"},     32'(bus.m_rst), 1);
        check({tag, "_m_wr"},      32'(bus.m_wr), 0);
        check({tag, "_m_addr"},    32'(bus.m_addr), 0);
        check({tag, "_m_din"},     32'(bus.m_din), 0);
    endtask

    task automatic wait_rsp(string tag);
        exp_t e;
        int   n = 0;
        while (!(|bus.rsp_valid) && n < 64) begin
            tick();
            n++;
        end
        check({tag, "_arrive"}, 32'(|bus.rsp_valid), 1);
        if (!(|bus.rsp_valid)) return;
        check({tag, "_sb"}, 32'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1 << e.idx));
        check({tag, "_rsp_err"},   32'(bus.rsp_err), 32'(e.err));
        check({tag, "_timeout"},   32'(bus.timeout), 32'(e.tmo));
        check({tag, "_m_rst_resp"}, 32'(bus.m_rst), 1);
        if (e.chk_dout) check({tag, "_rsp_dout"}, 32'(bus.rsp_dout), 32'(e.dout));
        tick();
        check({tag, "_pulse_end"}, 32'(bus.rsp_valid), 0);
        check({tag, "_idle_gnt"},  32'(bus.gnt), 0);
        check({tag, "_idle_mrst"}, 32'(bus.m_rst), 1);
        check({tag, "_tmo_end"},   32'(bus.timeout), 0);
    endtask

    // SPI interface model: done after SPI_LAT cycles out of hold, error for out-of-range addresses
    initial begin
        bus.m_done = 1'b0;
        bus.m_err  = 1'b0;
        bus.m_dout = '0;
        for (int i = 0; i < ADDR_LIMIT; i++) spi_mem[i] = 8'h00;
        forever begin
            tick();
            bus.m_done = 1'b0;
            bus.m_err  = 1'b0;
            bus.m_dout = '0;
            if (bus.m_rst) begin
                spi_cnt = 0;
            end else if (!spi_stall) begin
                spi_cnt++;
                if (err_glitch && spi_cnt == 1) bus.m_err = 1'b1;
                if (spi_cnt == SPI_LAT) begin
                    bus.m_done = 1'b1;
                    if (bus.m_addr >= 8'(ADDR_LIMIT)) bus.m_err = 1'b1;
                    else if (bus.m_wr) spi_mem[bus.m_addr[4:0]] = bus.m_din;
                    else bus.m_dout = spi_mem[bus.m_addr[4:0]];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=hang expected=finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int n;
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_wr   = '0;
        bus.req_addr = '0;
        bus.req_din  = '0;
        for (int i = 0; i < ADDR_LIMIT; i++) shadow[i] = 8'h00;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();
        check("idle_no_req_gnt", 32'(bus.gnt), 0);

        // single write from requester 0, request dropped during BUSY
        set_req(0, 1'b1, 8'd5, 8'hA5);
        bus.req = 2'b01;
        expect_txn(0, 1'b1, 8'd5, 8'hA5, 1'b0);
        tick();
        check("wr5_gnt",    32'(bus.gnt), 32'b01);
        check("wr5_m_rst",  32'(bus.m_rst), 0);
        check("wr5_m_wr",   32'(bus.m_wr), 1);
        check("wr5_m_addr", 32'(bus.m_addr), 5);
        check("wr5_m_din",  32'(bus.m_din), 32'hA5);
        bus.req = 2'b00;
        wait_rsp("wr5");

        // read back
        set_req(0, 1'b0, 8'd5, 8'h00);
        bus.req = 2'b01;
        expect_txn(0, 1'b0, 8'd5, 8'h00, 1'b0);
        tick();
        check("rd5_gnt",  32'(bus.gnt), 32'b01);
        check("rd5_m_wr", 32'(bus.m_wr), 0);
        bus.req = 2'b00;
        wait_rsp("rd5");

        // out-of-range write from requester 1 is forwarded and errors
        set_req(1, 1'b1, 8'd40, 8'h77);
        bus.req = 2'b10;
        expect_txn(1, 1'b1, 8'd40, 8'h77, 1'b0);
        tick();
        check("oob_gnt",    32'(bus.gnt), 32'b10);
        check("oob_m_addr", 32'(bus.m_addr), 40);
        bus.req = 2'b00;
        wait_rsp("oob");

        // both held: grants alternate 0,1,0,1
        set_req(0, 1'b0, 8'd5, 8'h00);
        set_req(1, 1'b1, 8'd9, 8'h5A);
        bus.req = 2'b11;
        expect_txn(0, 1'b0, 8'd5, 8'h00, 1'b0);
        expect_txn(1, 1'b1, 8'd9, 8'h5A, 1'b0);
        expect_txn(0, 1'b0, 8'd5, 8'h00, 1'b0);
        expect_txn(1, 1'b1, 8'd9, 8'h5A, 1'b0);
        for (int k = 0; k < 4; k++) wait_rsp("rr");
        bus.req = 2'b00;

        set_req(1, 1'b0, 8'd9, 8'h00);
        bus.req = 2'b10;
        expect_txn(1, 1'b0, 8'd9, 8'h00, 1'b0);
        tick();
        check("rd9_gnt", 32'(bus.gnt), 32'b10);
        bus.req = 2'b00;
        wait_rsp("rd9");

        // requester 1 raises and drops while requester 0 is being served: ignored
        set_req(0, 1'b0, 8'd5, 8'h00);
        bus.req = 2'b01;
        expect_txn(0, 1'b0, 8'd5, 8'h00, 1'b0);
        tick();
        check("drop_gnt", 32'(bus.gnt), 32'b01);
        bus.req = 2'b10;
        tick();
        bus.req = 2'b00;
        wait_rsp("drop");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("drop_no_gnt", 32'(bus.gnt), 0);
            check("drop_no_rsp", 32'(bus.rsp_valid), 0);
        end

        // m_err without m_done must not end BUSY
        err_glitch = 1'b1;
        bus.req = 2'b01;
        expect_txn(0, 1'b0, 8'd5, 8'h00, 1'b0);
        tick();
        bus.req = 2'b00;
        wait_rsp("glitch");
        err_glitch = 1'b0;

`ifdef SPI_MEM_ARB_TIMEOUT_EN
        spi_stall = 1'b1;
        bus.req = 2'b01;
        expect_txn(0, 1'b0, 8'd5, 8'h00, 1'b1);
        tick();
        check("tmo_gnt", 32'(bus.gnt), 32'b01);
        bus.req = 2'b00;
        n = 0;
        while (!(|bus.rsp_valid) && n < 100) begin
            tick();
            n++;
        end
        check("tmo_latency", 32'(n), 32'(TIMEOUT_CYCLES));
        wait_rsp("tmo");
        spi_stall = 1'b0;
`else
        spi_stall = 1'b1;
        bus.req = 2'b01;
        tick();
        check("nowdog_gnt", 32'(bus.gnt), 32'b01);
        bus.req = 2'b00;
        pulses = 0;
        repeat (40) begin
            tick();
            if (|bus.rsp_valid || bus.timeout) pulses++;
        end
        check("nowdog_pulses", 32'(pulses), 0);
        check("nowdog_still_gnt", 32'(bus.gnt), 32'b01);
        check("nowdog_m_rst", 32'(bus.m_rst), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        spi_stall = 1'b0;
        check_reset("nowdog_rst");
`endif

        // reset five cycles into BUSY aborts silently
        spi_stall = 1'b1;
        set_req(0, 1'b1, 8'd6, 8'h11);
        bus.req = 2'b01;
        tick();
        check("abort_gnt", 32'(bus.gnt), 32'b01);
        bus.req = 2'b00;
        pulses = 0;
        repeat (5) begin
            tick();
            if (|bus.rsp_valid) pulses++;
        end
        rst = 1'b1;
        tick();
        check_reset("abort_rst");
        rst = 1'b0;
        spi_stall = 1'b0;
        check("abort_no_rsp", 32'(pulses), 0);

        // after reset, requester 0 wins a tie again
        set_req(0, 1'b1, 8'd6, 8'hC3);
        set_req(1, 1'b0, 8'd5, 8'h00);
        bus.req = 2'b11;
        expect_txn(0, 1'b1, 8'd6, 8'hC3, 1'b0);
        tick();
        check("post_rst_gnt", 32'(bus.gnt), 32'b01);
        check("post_rst_m_din", 32'(bus.m_din), 32'hC3);
        bus.req = 2'b00;
        wait_rsp("post_rst");

        set_req(0, 1'b0, 8'd6, 8'h00);
        bus.req = 2'b01;
        expect_txn(0, 1'b0, 8'd6, 8'h00, 1'b0);
        tick();
        bus.req = 2'b00;
        wait_rsp("rd6");

        check("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
